// File: rtl/mac_result_checker.sv
// mac_result_checker: consumer end of the configurable-precision MAC interface.
// Recomputes a*b+c_in for every accepted triple and measures the error of the
// MAC output d against it. Per-sample records go into a first-word-fall-through
// FIFO, and run statistics accumulate as each record is pushed.
module mac_result_checker #(
    parameter int DATA_PATH_BITWIDTH = 32,
    parameter int FIFO_DEPTH         = 4,
    parameter int ERR_TOL            = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [15:0]                   num_samples,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_PATH_BITWIDTH-1:0] a,
    input  logic [DATA_PATH_BITWIDTH-1:0] b,
    input  logic [DATA_PATH_BITWIDTH-1:0] c_in,
    input  logic [DATA_PATH_BITWIDTH-1:0] d,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_PATH_BITWIDTH-1:0] out_exact,
    output logic [DATA_PATH_BITWIDTH:0]   out_err,
    output logic [15:0]                   mismatch_count,
    output logic [DATA_PATH_BITWIDTH:0]   max_abs_err,
    output logic [47:0]                   sum_abs_err,
    output logic                          busy,
    output logic                          done
);

    localparam int W  = DATA_PATH_BITWIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(FIFO_DEPTH);
    localparam logic [W:0]  TOL_L   = (W + 1)'(ERR_TOL);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]   state;
    logic [15:0]  num_reg;
    logic [15:0]  accepted;

    logic         s1_v;
    logic [W-1:0] s1_exact;
    logic [W-1:0] s1_d;
    logic         s2_v;
    logic [W-1:0] s2_exact;
    logic [W:0]   s2_err;
    logic [W:0]   s2_abs;

    logic [W-1:0] mem_exact [FIFO_DEPTH];
    logic [W:0]   mem_err   [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] fifo_count;

    logic         xfer;
    logic         push;
    logic         pop;
    logic         start_ok;
    logic [CW:0]  occupancy;
    logic [W-1:0] exact_next;
    logic [W:0]   err_next;
    logic [W:0]   abs_next;
    logic [48:0]  sum_ext;

    // Records in flight (pipeline plus FIFO) bound acceptance so a push can never overflow
    assign occupancy  = {1'b0, fifo_count} + {{CW{1'b0}}, s1_v} + {{CW{1'b0}}, s2_v};
    assign in_ready   = (state == RUN) && (occupancy < DEPTH_L) && (accepted < num_reg);
    assign xfer       = in_valid && in_ready;
    assign push       = s2_v;
    assign out_valid  = (fifo_count != '0);
    assign pop        = out_valid && out_ready;
    assign start_ok   = start && ((state == IDLE) || (state == DONE));
    assign busy       = (state == RUN) || (state == DRAIN);
    assign done       = (state == DONE);
    assign out_exact  = out_valid ? mem_exact[rd_ptr] : '0;
    assign out_err    = out_valid ? mem_err[rd_ptr]   : '0;

    assign exact_next = a * b + c_in;
    assign err_next   = {s1_d[W-1], s1_d} - {s1_exact[W-1], s1_exact};
    assign abs_next   = err_next[W] ? ((W + 1)'(0) - err_next) : err_next;
    assign sum_ext    = {1'b0, sum_abs_err} + 49'(s2_abs);

    // Run control: latch the sample count on start, count accepted triples, wait for drain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            num_reg  <= '0;
            accepted <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        num_reg  <= num_samples;
                        accepted <= '0;
                        state    <= (num_samples == 16'd0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        accepted <= accepted + 16'd1;
                        if (accepted + 16'd1 == num_reg) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!s1_v && !s2_v && (fifo_count == '0)) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Two-stage datapath: exact result first, then signed error and its magnitude
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_v     <= 1'b0;
            s1_exact <= '0;
            s1_d     <= '0;
            s2_v     <= 1'b0;
            s2_exact <= '0;
            s2_err   <= '0;
            s2_abs   <= '0;
        end else begin
            s1_v <= xfer;
            if (xfer) begin
                s1_exact <= exact_next;
                s1_d     <= d;
            end
            s2_v <= s1_v;
            if (s1_v) begin
                s2_exact <= s1_exact;
                s2_err   <= err_next;
                s2_abs   <= abs_next;
            end
        end
    end

    // FIFO pointers and occupancy; push and pop together leave the count unchanged
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Record storage needs no reset; the head is gated by out_valid
    always_ff @(posedge clk) begin
        if (push) begin
            mem_exact[wr_ptr] <= s2_exact;
            mem_err[wr_ptr]   <= s2_err;
        end
    end

    // Run statistics, cleared on an honoured start and updated on each FIFO push
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mismatch_count <= '0;
            max_abs_err    <= '0;
            sum_abs_err    <= '0;
        end else if (start_ok) begin
            mismatch_count <= '0;
            max_abs_err    <= '0;
            sum_abs_err    <= '0;
        end else if (push) begin
            if ((s2_abs > TOL_L) && (mismatch_count != 16'hFFFF))
                mismatch_count <= mismatch_count + 16'd1;
            if (s2_abs > max_abs_err)
                max_abs_err <= s2_abs;
            sum_abs_err <= sum_ext[48] ? 48'hFFFF_FFFF_FFFF : sum_ext[47:0];
        end
    end

endmodule

// File: tb/tb_mac_result_checker.sv
// tb_mac_result_checker: directed vectors with hand-computed expectations.
// Two instances share the stimulus: one with zero tolerance and one with a
// tolerance of 8 so the tolerance boundary is exercised on the same records.
module tb_mac_result_checker;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] num_samples;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c_in;
    logic [31:0] d;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_exact;
    logic [32:0] out_err;
    logic [15:0] mismatch_count;
    logic [32:0] max_abs_err;
    logic [47:0] sum_abs_err;
    logic        busy;
    logic        done;

    logic        t_in_ready;
    logic        t_out_valid;
    logic [31:0] t_out_exact;
    logic [32:0] t_out_err;
    logic [15:0] t_mismatch_count;
    logic [32:0] t_max_abs_err;
    logic [47:0] t_sum_abs_err;
    logic        t_busy;
    logic        t_done;

    int compared;
    int mismatched;
    int idx;

    logic [31:0] exact_q[$];
    logic [32:0] err_q[$];

    mac_result_checker #(.DATA_PATH_BITWIDTH(32), .FIFO_DEPTH(4), .ERR_TOL(0)) dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .d(d),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_exact(out_exact), .out_err(out_err),
        .mismatch_count(mismatch_count), .max_abs_err(max_abs_err),
        .sum_abs_err(sum_abs_err), .busy(busy), .done(done)
    );

    mac_result_checker #(.DATA_PATH_BITWIDTH(32), .FIFO_DEPTH(4), .ERR_TOL(8)) dut_tol (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(t_in_ready),
        .a(a), .b(b), .c_in(c_in), .d(d),
        .out_valid(t_out_valid), .out_ready(out_ready),
        .out_exact(t_out_exact), .out_err(t_out_err),
        .mismatch_count(t_mismatch_count), .max_abs_err(t_max_abs_err),
        .sum_abs_err(t_sum_abs_err), .busy(t_busy), .done(t_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Collect records popped from the zero-tolerance instance, in order
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            exact_q.push_back(out_exact);
            err_q.push_back(out_err);
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic pulseStart(input logic [15:0] n);
        num_samples = n;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] ta, input logic [31:0] tb_, input logic [31:0] tc, input logic [31:0] td);
        bit ok;
        ok = 1'b0;
        a = ta; b = tb_; c_in = tc; d = td;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!ok) checkOutput("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic waitDone(input string tag);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) break;
        end
        checkOutput(tag, 64'(done), 64'd1);
    endtask

    task automatic clearQueues();
        exact_q.delete();
        err_q.delete();
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        rst = 1'b0;
        start = 1'b0;
        num_samples = '0;
        in_valid = 1'b0;
        a = '0; b = '0; c_in = '0; d = '0;
        out_ready = 1'b0;

        // Reset state
        #3;
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_mismatch", 64'(mismatch_count), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("idle_in_ready", 64'(in_ready), 64'd0);

        // Basic run of three samples
        out_ready = 1'b1;
        clearQueues();
        pulseStart(16'd3);
        checkOutput("run_busy", 64'(busy), 64'd1);
        applyStimulus(32'd3, 32'd4, 32'd5, 32'd17);
        applyStimulus(-32'sd2, 32'd7, 32'd1, -32'sd13);
        applyStimulus(32'd100, 32'd100, 32'd0, 32'd10008);
        waitDone("basic_done");
        checkOutput("basic_count", 64'(exact_q.size()), 64'd3);
        if (exact_q.size() == 3) begin
            checkOutput("basic_exact0", 64'(exact_q[0]), 64'd17);
            checkOutput("basic_err0", 64'(err_q[0]), 64'd0);
            checkOutput("basic_exact1", 64'(exact_q[1]), 64'hFFFF_FFF3);
            checkOutput("basic_err1", 64'(err_q[1]), 64'd0);
            checkOutput("basic_exact2", 64'(exact_q[2]), 64'd10000);
            checkOutput("basic_err2", 64'(err_q[2]), 64'd8);
        end
        checkOutput("basic_mismatch", 64'(mismatch_count), 64'd1);
        checkOutput("basic_max", 64'(max_abs_err), 64'd8);
        checkOutput("basic_sum", 64'(sum_abs_err), 64'd8);
        checkOutput("basic_busy_off", 64'(busy), 64'd0);
        checkOutput("tol8_err8_mismatch", 64'(t_mismatch_count), 64'd0);
        checkOutput("tol8_done", 64'(t_done), 64'd1);

        // Wrapping exact result and largest representable error; restart from DONE
        clearQueues();
        pulseStart(16'd3);
        applyStimulus(32'h0001_0000, 32'h0001_0000, 32'd0, 32'd0);
        applyStimulus(32'h7FFF_FFFF, 32'd1, 32'd1, 32'h7FFF_FFFF);
        applyStimulus(32'd1, 32'd1, 32'd0, 32'd10);
        waitDone("wrap_done");
        checkOutput("wrap_count", 64'(exact_q.size()), 64'd3);
        if (exact_q.size() == 3) begin
            checkOutput("wrap_exact0", 64'(exact_q[0]), 64'd0);
            checkOutput("wrap_err0", 64'(err_q[0]), 64'd0);
            checkOutput("wrap_exact1", 64'(exact_q[1]), 64'h8000_0000);
            checkOutput("wrap_err1", 64'(err_q[1]), 64'h0_FFFF_FFFF);
            checkOutput("wrap_err2", 64'(err_q[2]), 64'd9);
        end
        checkOutput("wrap_mismatch", 64'(mismatch_count), 64'd2);
        checkOutput("wrap_max", 64'(max_abs_err), 64'hFFFF_FFFF);
        checkOutput("wrap_sum", 64'(sum_abs_err), 64'h1_0000_0008);
        checkOutput("tol8_err9_mismatch", 64'(t_mismatch_count), 64'd2);
        checkOutput("tol8_max", 64'(t_max_abs_err), 64'hFFFF_FFFF);

        // Zero-sample run goes straight to DONE with cleared statistics
        pulseStart(16'd0);
        checkOutput("zero_done", 64'(done), 64'd1);
        checkOutput("zero_busy", 64'(busy), 64'd0);
        checkOutput("zero_mismatch", 64'(mismatch_count), 64'd0);
        checkOutput("zero_max", 64'(max_abs_err), 64'd0);
        checkOutput("zero_sum", 64'(sum_abs_err), 64'd0);

        // Backpressure: consumer stalled, producer always valid
        clearQueues();
        out_ready = 1'b0;
        pulseStart(16'd6);
        idx = 0;
        a = 32'd0; b = 32'd2; c_in = 32'd1; d = 32'd1;
        in_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (in_ready) idx++;
            @(posedge clk);
            #1;
            a = 32'(idx);
            d = 32'(2 * idx + 1);
        end
        checkOutput("bp_accepted", 64'(idx), 64'd4);
        checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
        checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
        checkOutput("bp_head_exact", 64'(out_exact), 64'd1);
        checkOutput("bp_no_pop", 64'(exact_q.size()), 64'd0);
        pulseStart(16'd1);
        checkOutput("run_start_ignored_busy", 64'(busy), 64'd1);
        checkOutput("run_start_ignored_done", 64'(done), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("bp_head_stable", 64'(out_exact), 64'd1);
        checkOutput("bp_head_err_stable", 64'(out_err), 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) break;
            if (in_valid && in_ready) idx++;
            @(posedge clk);
            #1;
            a = 32'(idx);
            d = 32'(2 * idx + 1);
            if (idx >= 6) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        checkOutput("bp_done", 64'(done), 64'd1);
        checkOutput("bp_count", 64'(exact_q.size()), 64'd6);
        for (int i = 0; i < 6 && i < exact_q.size(); i++)
            checkOutput($sformatf("bp_order%0d", i), 64'(exact_q[i]), 64'(2 * i + 1));
        checkOutput("bp_mismatch", 64'(mismatch_count), 64'd0);

        // Reset in the middle of a run
        clearQueues();
        pulseStart(16'd5);
        applyStimulus(32'd1, 32'd1, 32'd0, 32'd2);
        applyStimulus(32'd2, 32'd2, 32'd0, 32'd3);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("mid_mismatch_before", 64'(mismatch_count), 64'd2);
        checkOutput("mid_sum_before", 64'(sum_abs_err), 64'd2);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_in_ready", 64'(in_ready), 64'd0);
        checkOutput("mid_rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("mid_rst_busy", 64'(busy), 64'd0);
        checkOutput("mid_rst_done", 64'(done), 64'd0);
        checkOutput("mid_rst_mismatch", 64'(mismatch_count), 64'd0);
        checkOutput("mid_rst_max", 64'(max_abs_err), 64'd0);
        checkOutput("mid_rst_sum", 64'(sum_abs_err), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        clearQueues();
        pulseStart(16'd1);
        applyStimulus(32'd2, 32'd3, 32'd4, 32'd10);
        waitDone("post_rst_done");
        checkOutput("post_rst_count", 64'(exact_q.size()), 64'd1);
        if (exact_q.size() == 1) checkOutput("post_rst_exact", 64'(exact_q[0]), 64'd10);
        checkOutput("post_rst_mismatch", 64'(mismatch_count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
